// File: rtl/puf_pkg.sv
// Shared types and defaults for the PUF response generator slice.
package puf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        CMP,
        DRAIN,
        DONE
    } state_t;

    localparam int unsigned DEF_CNT_BIT_SIZE = 5;
    localparam int unsigned DEF_N_BITS       = 8;
    localparam int unsigned DEF_TIMEOUT      = 1023;
    localparam int unsigned DEF_SYNC_STAGES  = 2;

    // Watchdog must be able to hold the value TIMEOUT itself.
    function automatic int unsigned wd_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/puf_sync.sv
// Multi-flop synchronizer for one asynchronous level signal.
module puf_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/puf_resp_gen.sv
// Sequences RO-pair enables, synchronizes their valids and packs one
// comparison bit per pair into a response word behind a valid/ready handshake.
module puf_resp_gen
    import puf_pkg::*;
#(
    parameter int unsigned CNT_BIT_SIZE = DEF_CNT_BIT_SIZE,
    parameter int unsigned N_BITS       = DEF_N_BITS,
    parameter int unsigned TIMEOUT      = DEF_TIMEOUT,
    parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_start,
    output logic                      o_busy,
    output logic                      o_puf_en,
    output logic [$clog2(N_BITS)-1:0] o_sel,
    input  logic                      i_valid_a,
    input  logic                      i_valid_b,
    input  logic [CNT_BIT_SIZE-1:0]   i_count_a,
    input  logic [CNT_BIT_SIZE-1:0]   i_count_b,
    output logic [N_BITS-1:0]         o_resp,
    output logic                      o_resp_valid,
    input  logic                      i_resp_ready,
    output logic                      o_tie,
    output logic                      o_timeout
);

    localparam int unsigned SEL_W = $clog2(N_BITS);
    localparam int unsigned WD_W  = wd_width(TIMEOUT);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [N_BITS-1:0] resp_q, resp_d;
    logic              tie_q, tie_d;
    logic              timeout_q, timeout_d;
    logic              puf_en_q, puf_en_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [WD_W-1:0]   wd_inc;
    logic              valid_a_s, valid_b_s;

    puf_sync #(.STAGES(SYNC_STAGES)) u_sync_a (
        .clk (clk),
        .rst (rst),
        .d   (i_valid_a),
        .q   (valid_a_s)
    );

    puf_sync #(.STAGES(SYNC_STAGES)) u_sync_b (
        .clk (clk),
        .rst (rst),
        .d   (i_valid_b),
        .q   (valid_b_s)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        resp_d    = resp_q;
        tie_d     = tie_q;
        timeout_d = timeout_q;
        wd_d      = wd_q;
        wd_inc    = wd_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d   = RUN;
                    resp_d    = '0;
                    tie_d     = 1'b0;
                    timeout_d = 1'b0;
                    wd_d      = '0;
                end
            end
            RUN: begin
                // Both valids take priority over a coincident watchdog expiry.
                if (valid_a_s && valid_b_s) begin
                    state_d = CMP;
                end else if (wd_inc == WD_W'(TIMEOUT)) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    wd_d = wd_inc;
                end
            end
            CMP: begin
                resp_d[sel_q] = (i_count_a > i_count_b);
                if (i_count_a == i_count_b) begin
                    tie_d = 1'b1;
                end
                state_d = DRAIN;
                wd_d    = '0;
            end
            DRAIN: begin
                if (!valid_a_s && !valid_b_s) begin
                    if (sel_q == SEL_W'(N_BITS - 1)) begin
                        state_d = DONE;
                    end else begin
                        sel_d   = sel_q + 1'b1;
                        state_d = RUN;
                        wd_d    = '0;
                    end
                end else if (wd_inc == WD_W'(TIMEOUT)) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    wd_d = wd_inc;
                end
            end
            DONE: begin
                if (i_resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == IDLE) begin
            sel_d = '0;
        end
        // Enable stays high through CMP so the counts are still held when sampled.
        puf_en_d = (state_d == RUN) || (state_d == CMP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            resp_q    <= '0;
            tie_q     <= 1'b0;
            timeout_q <= 1'b0;
            puf_en_q  <= 1'b0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            resp_q    <= resp_d;
            tie_q     <= tie_d;
            timeout_q <= timeout_d;
            puf_en_q  <= puf_en_d;
            wd_q      <= wd_d;
        end
    end

    assign o_busy       = (state_q != IDLE);
    assign o_resp_valid = (state_q == DONE);
    assign o_puf_en     = puf_en_q;
    assign o_sel        = sel_q;
    assign o_resp       = resp_q;
    assign o_tie        = tie_q;
    assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_puf_resp_gen.sv
// Randomized bench for puf_resp_gen with behavioural PUF stages and a
// response model derived directly from the per-pair count tables.
module tb_puf_resp_gen;

    localparam int unsigned CW    = 5;
    localparam int unsigned NB    = 8;
    localparam int unsigned TMO   = 50;
    localparam int unsigned SS    = 2;
    localparam int unsigned SEL_W = 3;
    localparam int          NEVER = 100000;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_start;
    logic             o_busy;
    logic             o_puf_en;
    logic [SEL_W-1:0] o_sel;
    logic             i_valid_a, i_valid_b;
    logic [CW-1:0]    i_count_a, i_count_b;
    logic [NB-1:0]    o_resp;
    logic             o_resp_valid;
    logic             i_resp_ready;
    logic             o_tie;
    logic             o_timeout;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [CW-1:0] cnt_a [NB];
    logic [CW-1:0] cnt_b [NB];
    int            dly_a [NB];
    int            dly_b [NB];
    logic [NB-1:0] exp_resp;
    logic          exp_tie;

    always #5 clk = ~clk;

    puf_resp_gen #(
        .CNT_BIT_SIZE (CW),
        .N_BITS       (NB),
        .TIMEOUT      (TMO),
        .SYNC_STAGES  (SS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .o_busy       (o_busy),
        .o_puf_en     (o_puf_en),
        .o_sel        (o_sel),
        .i_valid_a    (i_valid_a),
        .i_valid_b    (i_valid_b),
        .i_count_a    (i_count_a),
        .i_count_b    (i_count_b),
        .o_resp       (o_resp),
        .o_resp_valid (o_resp_valid),
        .i_resp_ready (i_resp_ready),
        .o_tie        (o_tie),
        .o_timeout    (o_timeout)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Response is simply "A beats B" per pair; a tie anywhere flags the word.
    task automatic model_expect();
        exp_resp = '0;
        exp_tie  = 1'b0;
        for (int k = 0; k < NB; k++) begin
            exp_resp[k] = (cnt_a[k] > cnt_b[k]);
            if (cnt_a[k] == cnt_b[k]) exp_tie = 1'b1;
        end
    endtask

    task automatic randomize_tables(input int dmin, input int dmax);
        for (int k = 0; k < NB; k++) begin
            cnt_a[k] = CW'($urandom_range(0, 31));
            cnt_b[k] = ($urandom_range(0, 7) == 0) ? cnt_a[k] : CW'($urandom_range(0, 31));
            dly_a[k] = $urandom_range(dmin, dmax);
            dly_b[k] = $urandom_range(dmin, dmax);
        end
    endtask

    task automatic start_pulse();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("start_busy_en", {30'd0, o_busy, o_puf_en}, 32'd3);
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 3000; i++) begin
            if (o_resp_valid) break;
            @(negedge clk);
        end
        check("done_wait", {31'd0, o_resp_valid}, 32'd1);
    endtask

    task automatic finish_hs(input int hold);
        repeat (hold) @(negedge clk);
        i_resp_ready = 1'b1;
        @(negedge clk);
        i_resp_ready = 1'b0;
        check("hs_idle", {30'd0, o_busy, o_resp_valid}, 32'd0);
        check("resp_held", {24'd0, o_resp}, {24'd0, exp_resp});
    endtask

    task automatic full_challenge(input int hold);
        model_expect();
        start_pulse();
        wait_done();
        finish_hs(hold);
    endtask

    // Per-cycle compare process plus the two PUF stage models (same process,
    // so checks see the state before the stages react to this cycle).
    initial begin
        int   tmr_a, tmr_b, rise_a, rise_b, run_len, low_len, model_sel, mx;
        logic prev_en, prev_busy;
        tmr_a = 0; tmr_b = 0; rise_a = -1; rise_b = -1;
        run_len = 0; low_len = 0; model_sel = 0;
        prev_en = 1'b0; prev_busy = 1'b0;
        i_valid_a = 1'b0; i_valid_b = 1'b0; i_count_a = '0; i_count_b = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!o_busy)
                check("idle_outs", {27'd0, o_puf_en, o_sel, o_resp_valid}, 32'd0);
            if (o_resp_valid)
                check("done_word", {22'd0, o_resp, o_tie, o_timeout}, {22'd0, exp_resp, exp_tie, 1'b0});
            if (o_puf_en && !prev_en) begin
                if (!prev_busy) begin
                    model_sel = 0;
                end else begin
                    model_sel++;
                    check("drain_len", low_len, SS + 1);
                end
                run_len = 0;
            end
            if (!o_puf_en && prev_en) begin
                if (o_timeout) begin
                    check("timeout_len", run_len, TMO);
                end else if (o_busy && rise_a >= 0 && rise_b >= 0) begin
                    mx = (rise_a > rise_b) ? rise_a : rise_b;
                    check("cmp_latency", cyc - mx, SS + 2);
                end
                low_len = 0;
            end
            if (o_puf_en) begin
                run_len++;
                check("sel", {29'd0, o_sel}, model_sel);
            end else begin
                low_len++;
            end

            if (!o_puf_en) begin
                i_valid_a = 1'b0; i_valid_b = 1'b0;
                i_count_a = '0;   i_count_b = '0;
                tmr_a = 0; tmr_b = 0; rise_a = -1; rise_b = -1;
            end else begin
                tmr_a++;
                tmr_b++;
                if (tmr_a == dly_a[o_sel]) begin
                    i_valid_a = 1'b1; i_count_a = cnt_a[o_sel]; rise_a = cyc;
                end
                if (tmr_b == dly_b[o_sel]) begin
                    i_valid_b = 1'b1; i_count_b = cnt_b[o_sel]; rise_b = cyc;
                end
            end
            prev_en   = o_puf_en;
            prev_busy = o_busy;
        end
    end

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit saw_rv;
        int i;
        logic [NB-1:0] held;
        rst = 1'b1; i_start = 1'b0; i_resp_ready = 1'b0;
        for (int k = 0; k < NB; k++) begin
            cnt_a[k] = '0; cnt_b[k] = '0; dly_a[k] = 20; dly_b[k] = 20;
        end
        exp_resp = '0; exp_tie = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",    {31'd0, o_busy},       32'd0);
        check("rst_puf_en",  {31'd0, o_puf_en},     32'd0);
        check("rst_sel",     {29'd0, o_sel},        32'd0);
        check("rst_resp",    {24'd0, o_resp},       32'd0);
        check("rst_rv",      {31'd0, o_resp_valid}, 32'd0);
        check("rst_flags",   {30'd0, o_tie, o_timeout}, 32'd0);
        rst = 1'b0;

        // Basic challenge with hand-picked counts.
        cnt_a = '{5'd9, 5'd3, 5'd12, 5'd20, 5'd1, 5'd5, 5'd31, 5'd0};
        cnt_b = '{5'd4, 5'd7, 5'd10, 5'd2,  5'd8, 5'd6, 5'd30, 5'd15};
        model_expect();
        check("model_basic", {24'd0, exp_resp}, 32'h4D);
        start_pulse();
        wait_done();
        check("basic_resp", {24'd0, o_resp}, 32'h4D);
        check("basic_tie",  {31'd0, o_tie},  32'd0);
        finish_hs(0);

        // Tie on pair 3.
        randomize_tables(20, 20);
        cnt_a[3] = 5'd17; cnt_b[3] = 5'd17;
        model_expect();
        start_pulse();
        wait_done();
        check("tie_bit3", {31'd0, o_resp[3]}, 32'd0);
        check("tie_flag", {31'd0, o_tie},     32'd1);
        finish_hs(2);

        // Timeout: valid B never rises on pair 0.
        randomize_tables(3, 20);
        dly_b[0] = NEVER;
        model_expect();
        start_pulse();
        saw_rv = 1'b0;
        for (i = 0; i < 200; i++) begin
            if (!o_busy) break;
            if (o_resp_valid) saw_rv = 1'b1;
            @(negedge clk);
        end
        check("to_flag",   {31'd0, o_timeout}, 32'd1);
        check("to_idle",   {30'd0, o_busy, o_puf_en}, 32'd0);
        check("to_no_rv",  {31'd0, saw_rv},    32'd0);
        randomize_tables(3, 20);
        model_expect();
        start_pulse();
        check("to_cleared", {31'd0, o_timeout}, 32'd0);
        wait_done();
        finish_hs(3);

        // Back-pressure in DONE, with a stray start that must be ignored.
        randomize_tables(2, 25);
        model_expect();
        start_pulse();
        wait_done();
        held = o_resp;
        for (i = 0; i < 10; i++) begin
            i_start = (i == 4);
            @(negedge clk);
            check("bp_valid",  {31'd0, o_resp_valid}, 32'd1);
            check("bp_stable", {24'd0, o_resp}, {24'd0, held});
        end
        i_start = 1'b0;
        finish_hs(0);
        @(negedge clk);
        check("bp_start_ignored", {31'd0, o_busy}, 32'd0);

        // Reset while working on pair 4.
        randomize_tables(2, 25);
        model_expect();
        start_pulse();
        for (i = 0; i < 2000; i++) begin
            if (o_sel == 3'd4 && o_puf_en) break;
            @(negedge clk);
        end
        check("rst_reach_sel4", {29'd0, o_sel}, 32'd4);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ctl",  {27'd0, o_busy, o_puf_en, o_sel}, 32'd0);
        check("midrst_resp", {22'd0, o_resp, o_tie, o_timeout}, 32'd0);
        rst = 1'b0;
        randomize_tables(2, 25);
        model_expect();
        start_pulse();
        check("post_rst_sel", {29'd0, o_sel}, 32'd0);
        wait_done();
        finish_hs(1);

        // Skewed valids: A far ahead of B on every pair.
        randomize_tables(5, 5);
        for (int k = 0; k < NB; k++) dly_b[k] = 35;
        full_challenge(0);

        // Random challenges.
        for (int n = 0; n < 5; n++) begin
            randomize_tables(2, 25);
            full_challenge($urandom_range(0, 5));
        end

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
